hazard_unit: RTL and testbench
==============================

# hazard_unit

- Generates pipeline control for the five-stage core:
  - stage-register enables and synchronous clears for the F/D, D/E and E/M registers;
  - E-stage operand forwarding selects.
- Owns a small state machine that freezes the front of the pipeline while a multi-cycle multiply/divide op occupies E.
- It is the producer of the `en`/`clear` controls consumed by the fetch/decode and decode/execute stage registers.

## Interface

Parameters
- `MD_CYCLES`, default 8: total cycles a multi-cycle op occupies E. Legal range is ≥2.
- `CNT_W`, default `$clog2(MD_CYCLES)`: width of the busy counter.

Ports
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs1_d`, `rs2_d` in 5: source registers of the instruction in D.
- `rs1_e`, `rs2_e`, `rd_e` in 5: sources and destination of the instruction in E.
- `rd_m`, `rd_w` in 5: destinations in M and W.
- `reg_write_m`, `reg_write_w` in 1: the M / W instruction writes the register file.
- `load_e` in 1: the instruction in E is a load.
- `pc_src_e` in 1: a taken branch or jump is resolved in E.
- `md_start_e` in 1: the instruction in E is a multi-cycle mul/div op.
- `en_f`, `en_d`, `en_e` out 1: PC, F/D and D/E register enables. 0 means hold.
- `clear_d`, `clear_e`, `clear_m` out 1: flush (bubble insert) for F/D, D/E and E/M.
- `forward_a_e`, `forward_b_e` out 2: ALU operand select. 00 = register file, 01 = W result, 10 = M result.
- `md_busy` out 1: the multi-cycle FSM is stalling.
- `md_done` out 1: one-cycle pulse on the release cycle of a multi-cycle op.

## Operation

- Forwarding, per operand (shown for A, same for B with `rs2_e`):
  - 10 if `reg_write_m` && `rd_m`≠0 && `rd_m`==`rs1_e`.
  - Otherwise 01 if `reg_write_w` && `rd_w`≠0 && `rd_w`==`rs1_e`.
  - Otherwise 00.
  - M has priority over W. x0 is never forwarded.
- Load-use: `lw_stall` = `load_e` && `rd_e`≠0 && (`rd_e`==`rs1_d` || `rd_e`==`rs2_d`).
- FSM states are IDLE and BUSY. The counter `cnt` has width `CNT_W`.
- In IDLE:
  - If `md_start_e`: `md_stall`=1, go to BUSY, load `cnt`=MD_CYCLES-2.
  - Otherwise stay in IDLE.
- In BUSY:
  - If `cnt`≠0: `md_stall`=1 and decrement `cnt`.
  - If `cnt`==0: `md_stall`=0, `md_done`=1, go to IDLE.
- `md_busy` = `md_stall`.
- Control priority, highest first:
  1. `md_stall`: `en_f`=`en_d`=`en_e`=0, `clear_m`=1, `clear_d`=`clear_e`=0. Branch and load-use are ignored this cycle.
  2. `pc_src_e`: `en_f`=`en_d`=`en_e`=1, `clear_d`=1, `clear_e`=1.
  3. `lw_stall`: `en_f`=`en_d`=0, `en_e`=1, `clear_e`=1.
  4. Default: all enables 1, all clears 0.
- Forward selects are computed every cycle regardless of stalls.
- In legal code, load, branch and md op in E are mutually exclusive. If several are asserted at once, the priority above applies.
- In the release cycle (BUSY, `cnt`==0), `md_start_e` still reads high for the same instruction. It must not retrigger: BUSY ignores `md_start_e`.
- A new md op arriving in E on the cycle after release starts a fresh sequence from IDLE.

## Timing

- Forwarding, load-use, branch and clear outputs are combinational from the inputs, with zero latency.
- `md_stall`/`md_done` are combinational from the state, `cnt` and `md_start_e`.
- An md op occupies E for exactly MD_CYCLES cycles:
  - MD_CYCLES-1 of them are stall cycles.
  - The last is the release cycle, where `md_done`=1.
- Reset (async assert, sync-to-`clk` deassert usage):
  - state=IDLE, `cnt`=0.
  - While `rst`=1, outputs are forced: `en_f`=`en_d`=`en_e`=1, all clears 0, forwards 00, `md_busy`=0, `md_done`=0.
- Reset mid-BUSY aborts the sequence immediately. No `md_done` pulse is produced.

## Test plan

- Forwarding:
  - `rs1_e`=5, `rd_m`=5, `reg_write_m`=1, `rd_w`=5, `reg_write_w`=1 -> `forward_a_e`=10.
  - Drop `reg_write_m` -> 01.
  - Set `rd_m`=`rd_w`=0 with `rs1_e`=0 -> 00.
- Load-use: `load_e`=1, `rd_e`=7, `rs2_d`=7 -> `en_f`=`en_d`=0, `clear_e`=1 for one cycle.
  - Same stimulus with `rd_e`=0 -> no stall.
- Branch: `pc_src_e`=1 -> `clear_d`=`clear_e`=1, enables 1.
  - Also assert `load_e`, `rd_e`=3, `rs1_d`=3 -> branch response wins.
- Multi-cycle op, MD_CYCLES=8: pulse `md_start_e` and hold it high while stalled.
  - Expect 7 cycles of `en_f`=`en_d`=`en_e`=0 and `clear_m`=1.
  - Then 1 cycle with `md_done`=1 and enables 1.
  - Back-to-back ops give two 7+1 sequences with no gap.
- Stall priority: during BUSY, assert `pc_src_e` and a load-use hazard -> only the md freeze is visible, `clear_d`=`clear_e`=0.
- Reset mid-op: assert `rst` at stall cycle 3 -> outputs immediately take their reset values.
  - After deassert, with `md_start_e`=0, stay in IDLE with no `md_done`.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the five-stage core: E-stage forwarding selects,
// load-use and branch flushes, and a front-end freeze while a multi-cycle mul/div holds E.
module hazard_unit #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       load_e,
  input  logic       pc_src_e,
  input  logic       md_start_e,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       clear_d,
  output logic       clear_e,
  output logic       clear_m,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             md_stall;
  logic             md_release;
  logic             lw_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // M wins over W because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] dst_m,
    input logic       we_m,
    input logic [4:0] dst_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (dst_m != 5'd0) && (dst_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (dst_w != 5'd0) && (dst_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  assign lw_stall = load_e && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // The IDLE start cycle is the first stall cycle, so BUSY counts MD_CYCLES-2
  // further stalls before the release cycle at cnt==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (md_start_e) begin
            state <= BUSY;
            cnt   <= CNT_W'(MD_CYCLES - 2);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // BUSY deliberately ignores md_start_e: it stays high through the release cycle.
  always_comb begin
    md_stall   = 1'b0;
    md_release = 1'b0;
    unique case (state)
      IDLE: md_stall = md_start_e;
      BUSY: begin
        if (cnt != '0) begin
          md_stall = 1'b1;
        end else begin
          md_release = 1'b1;
        end
      end
      default: begin
        md_stall   = 1'b0;
        md_release = 1'b0;
      end
    endcase
  end

  always_comb begin
    en_f        = 1'b1;
    en_d        = 1'b1;
    en_e        = 1'b1;
    clear_d     = 1'b0;
    clear_e     = 1'b0;
    clear_m     = 1'b0;
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (!rst) begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      md_busy     = md_stall;
      md_done     = md_release;
      if (md_stall) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        clear_m = 1'b1;
      end else if (pc_src_e) begin
        clear_d = 1'b1;
        clear_e = 1'b1;
      end else if (lw_stall) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        clear_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed test-plan steps followed by random traffic,
// each cycle compared against a cycle-count model of the pipeline control rules.
module tb_hazard_unit;

  localparam int MD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, load_e, pc_src_e, md_start_e;
  logic       en_f, en_d, en_e, clear_d, clear_e, clear_m;
  logic [1:0] forward_a_e, forward_b_e;
  logic       md_busy, md_done;

  int vectors     = 0;
  int miscompares = 0;
  // Cycles the current md op still holds E, counting the present one; 0 = none.
  int md_left     = 0;

  hazard_unit #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .md_start_e(md_start_e),
    .en_f(en_f), .en_d(en_d), .en_e(en_e),
    .clear_d(clear_d), .clear_e(clear_e), .clear_m(clear_m),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'd2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Packed as {en_f,en_d,en_e,clear_d,clear_e,clear_m,md_busy,md_done,fwd_a,fwd_b}.
  function automatic logic [11:0] model_out();
    logic stall, done, lw;
    logic [2:0] en;
    logic [2:0] clr;
    if (rst) return {3'b111, 3'b000, 2'b00, 4'b0000};
    stall = (md_left == 0 && md_start_e) || (md_left > 1);
    done  = (md_left == 1);
    lw    = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    en  = 3'b111;
    clr = 3'b000;
    if (stall)         begin en = 3'b000; clr = 3'b001; end
    else if (pc_src_e) begin clr = 3'b110; end
    else if (lw)       begin en = 3'b001; clr = 3'b010; end
    return {en, clr, stall, done, model_fwd(rs1_e), model_fwd(rs2_e)};
  endfunction

  task automatic zero_inputs();
    rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; load_e = 0; pc_src_e = 0; md_start_e = 0;
  endtask

  // Inputs are already driven; check mid-cycle, then advance the model on the edge.
  task automatic step(input string tag);
    logic [11:0] obs, exp;
    @(negedge clk);
    exp = model_out();
    obs = {en_f, en_d, en_e, clear_d, clear_e, clear_m, md_busy, md_done,
           forward_a_e, forward_b_e};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%03h expected=%03h md_left=%0d", tag, obs, exp, md_left);
    end
    @(posedge clk);
    if (rst) md_left = 0;
    else if (md_left == 0 && md_start_e) md_left = MD_CYCLES - 1;
    else if (md_left > 0) md_left--;
    #1;
  endtask

  initial begin
    zero_inputs();
    rst = 1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1;
    #1;
    step("reset_forced");
    step("reset_forced2");
    zero_inputs();

    // Forwarding
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    step("fwd_m_priority");
    reg_write_m = 0;
    step("fwd_w");
    rs1_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1;
    step("fwd_x0");
    rs2_e = 9; rd_w = 9;
    step("fwd_b_w");
    zero_inputs();

    // Load-use
    load_e = 1; rd_e = 7; rs2_d = 7;
    step("load_use");
    rd_e = 0;
    step("load_use_x0");
    zero_inputs();

    // Branch, and branch beating load-use
    pc_src_e = 1;
    step("branch");
    load_e = 1; rd_e = 3; rs1_d = 3;
    step("branch_over_lw");
    zero_inputs();

    // Multi-cycle op, md_start_e held through the release cycle
    md_start_e = 1;
    for (int i = 0; i < MD_CYCLES; i++) step("md_single");
    // Back-to-back: two full sequences with no gap
    for (int i = 0; i < 2 * MD_CYCLES; i++) step("md_b2b");
    md_start_e = 0;
    step("md_idle_after");

    // Branch and load-use during BUSY are masked by the freeze
    md_start_e = 1;
    step("md_start");
    pc_src_e = 1; load_e = 1; rd_e = 4; rs1_d = 4;
    for (int i = 0; i < MD_CYCLES - 2; i++) step("md_masks_ctrl");
    pc_src_e = 0; load_e = 0;
    step("md_release");
    zero_inputs();

    // Reset at stall cycle 3
    md_start_e = 1;
    for (int i = 0; i < 3; i++) step("md_pre_reset");
    rst = 1;
    #1;
    vectors++;
    assert ({en_f, en_d, en_e, clear_m, md_busy} === 5'b11100) else begin
      miscompares++;
      $error("FAIL reset_async observed=%05b expected=11100",
             {en_f, en_d, en_e, clear_m, md_busy});
    end
    step("reset_mid_op");
    rst = 0; md_start_e = 0;
    for (int i = 0; i < MD_CYCLES; i++) step("post_reset_idle");

    // Random traffic over a narrow register range to hit matches often
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      rs1_d       = 5'($urandom_range(0, 3));
      rs2_d       = 5'($urandom_range(0, 3));
      rs1_e       = 5'($urandom_range(0, 3));
      rs2_e       = 5'($urandom_range(0, 3));
      rd_e        = 5'($urandom_range(0, 3));
      rd_m        = 5'($urandom_range(0, 3));
      rd_w        = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      load_e      = ($urandom_range(0, 3) == 0);
      pc_src_e    = ($urandom_range(0, 4) == 0);
      md_start_e  = (md_left > 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
      #1;
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
